// File: rtl/elevator_scan_controller.sv
// elevator_scan_controller: multi-call SCAN elevator controller with timed door dwell
module elevator_scan_controller #(
    parameter int NUM_FLOORS   = 10,
    parameter int FLOOR_W      = 4,
    parameter int TRAVEL_TICKS = 10000000,
    parameter int DOOR_TICKS   = 20000000,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  idle
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] MOVE_UP   = 2'd1;
    localparam logic [1:0] MOVE_DOWN = 2'd2;
    localparam logic [1:0] DOOR_OPEN = 2'd3;

    logic [1:0]            state, state_d;
    logic [FLOOR_W-1:0]    floor_d, nxt;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic                  dir_up, dir_d;
    logic [NUM_FLOORS-1:0] req, cur_mask, nxt_mask, clear;
    logic                  above, below, ahead_up, ahead_dn, at_cur, at_nxt;
    logic                  travel_done, door_done;

    // Scan the merged request set relative to the current floor and the floor being approached
    always_comb begin
        req      = pending | call_req;
        nxt      = (state == MOVE_UP) ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);
        cur_mask = '0;
        nxt_mask = '0;
        above    = 1'b0;
        below    = 1'b0;
        ahead_up = 1'b0;
        ahead_dn = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cur_mask[i] = (FLOOR_W'(i) == current_floor);
            nxt_mask[i] = (FLOOR_W'(i) == nxt);
            above       = above    | (req[i] && (FLOOR_W'(i) > current_floor));
            below       = below    | (req[i] && (FLOOR_W'(i) < current_floor));
            ahead_up    = ahead_up | (req[i] && (FLOOR_W'(i) > nxt));
            ahead_dn    = ahead_dn | (req[i] && (FLOOR_W'(i) < nxt));
        end
        at_cur = |(req & cur_mask);
        at_nxt = |(req & nxt_mask);
    end

    // Next-state, floor, counter, direction and the pending bit serviced this edge
    always_comb begin
        state_d     = state;
        floor_d     = current_floor;
        cnt_d       = '0;
        dir_d       = dir_up;
        clear       = '0;
        travel_done = (cnt == CNT_W'(TRAVEL_TICKS - 1));
        door_done   = (cnt == CNT_W'(DOOR_TICKS - 1));
        case (state)
            IDLE: begin
                clear = cur_mask;
                if (at_cur) begin
                    state_d = DOOR_OPEN;
                end else if (above && (dir_up || !below)) begin
                    state_d = MOVE_UP;
                    dir_d   = 1'b1;
                end else if (below) begin
                    state_d = MOVE_DOWN;
                    dir_d   = 1'b0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                cnt_d = cnt + CNT_W'(1);
                if (travel_done) begin
                    cnt_d   = '0;
                    floor_d = nxt;
                    if (at_nxt) begin
                        state_d = DOOR_OPEN;
                        clear   = nxt_mask;
                    end else if (!((state == MOVE_UP) ? ahead_up : ahead_dn)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                clear = cur_mask;
                if (|(call_req & cur_mask)) cnt_d = '0;
                else if (door_done) state_d = IDLE;
                else cnt_d = cnt + CNT_W'(1);
            end
        endcase
    end

    // State registers; a reset drops every latched call
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            current_floor <= '0;
            pending       <= '0;
            cnt           <= '0;
            dir_up        <= 1'b1;
        end else begin
            state         <= state_d;
            current_floor <= floor_d;
            pending       <= (pending | call_req) & ~clear;
            cnt           <= cnt_d;
            dir_up        <= dir_d;
        end
    end

    assign idle        = (state == IDLE);
    assign moving_up   = (state == MOVE_UP);
    assign moving_down = (state == MOVE_DOWN);
    assign door_open   = (state == DOOR_OPEN);
endmodule

// File: tb/tb_elevator_scan_controller.sv
// tb_elevator_scan_controller: directed and random checks against a SCAN reference model
module tb_elevator_scan_controller;
    localparam int NF = 8;
    localparam int TT = 4;
    localparam int DT = 3;
    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] call_req = '0;
    logic [3:0]    current_floor;
    logic [NF-1:0] pending;
    logic          door_open, moving_up, moving_down, idle;

    int errors = 0;
    int checks = 0;

    int      m_floor, m_mode, m_left;
    bit      m_up;
    bit [7:0] m_pend;

    elevator_scan_controller #(
        .NUM_FLOORS(NF), .FLOOR_W(4), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .call_req(call_req), .current_floor(current_floor),
        .pending(pending), .door_open(door_open), .moving_up(moving_up),
        .moving_down(moving_down), .idle(idle)
    );

    always #5 clk = ~clk;

    function automatic bit any_range(bit [7:0] r, int lo, int hi);
        for (int i = lo; i <= hi; i++) if (i >= 0 && i < NF && r[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_floor = 0;
        m_mode  = M_IDLE;
        m_left  = 0;
        m_up    = 1'b1;
        m_pend  = '0;
    endfunction

    function automatic void model_step(bit [7:0] c);
        bit [7:0] r;
        r = m_pend | c;
        if (m_mode == M_IDLE) begin
            if (r[m_floor]) begin
                m_mode = M_DOOR;
                m_left = DT;
            end else if (any_range(r, m_floor + 1, NF - 1) && (m_up || !any_range(r, 0, m_floor - 1))) begin
                m_mode = M_UP;
                m_up   = 1'b1;
                m_left = TT;
            end else if (any_range(r, 0, m_floor - 1)) begin
                m_mode = M_DOWN;
                m_up   = 1'b0;
                m_left = TT;
            end
            r[m_floor] = 1'b0;
        end else if (m_mode == M_DOOR) begin
            if (c[m_floor]) m_left = DT;
            else m_left--;
            if (m_left == 0) m_mode = M_IDLE;
            r[m_floor] = 1'b0;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_floor += (m_mode == M_UP) ? 1 : -1;
                m_left = TT;
                if (r[m_floor]) begin
                    r[m_floor] = 1'b0;
                    m_mode = M_DOOR;
                    m_left = DT;
                end else if (!((m_mode == M_UP) ? any_range(r, m_floor + 1, NF - 1) : any_range(r, 0, m_floor - 1))) begin
                    m_mode = M_IDLE;
                end
            end
        end
        m_pend = r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " floor"}, 32'(current_floor), 32'(m_floor));
        chk({tag, " pending"}, 32'(pending), 32'(m_pend));
        chk({tag, " idle"}, 32'(idle), 32'(m_mode == M_IDLE));
        chk({tag, " door"}, 32'(door_open), 32'(m_mode == M_DOOR));
        chk({tag, " up"}, 32'(moving_up), 32'(m_mode == M_UP));
        chk({tag, " down"}, 32'(moving_down), 32'(m_mode == M_DOWN));
        chk({tag, " onehot"}, 32'($countones({idle, door_open, moving_up, moving_down})), 32'd1);
    endtask

    task automatic tick(input logic [7:0] c, input string tag);
        call_req = c;
        model_step(c);
        @(posedge clk);
        #1;
        call_req = '0;
        check_all(tag);
    endtask

    task automatic run_quiet(input string tag);
        for (int n = 0; n < 300 && !(m_mode == M_IDLE && m_pend == 0); n++) tick(8'h00, tag);
        chk({tag, " quiet idle"}, 32'(idle), 32'd1);
        chk({tag, " quiet pending"}, 32'(pending), 32'd0);
    endtask

    initial begin
        int first_door;
        int door_cnt;
        logic [7:0] seq [7];
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) tick(8'h00, "no_calls");

        tick(8'h08, "call3");
        chk("call3 moving_up", 32'(moving_up), 32'd1);
        first_door = -1;
        for (int n = 1; n <= 40 && first_door < 0; n++) begin
            tick(8'h00, "to3");
            if (door_open) first_door = n;
        end
        chk("call3 latency", 32'(first_door), 32'd12);
        run_quiet("to3");
        chk("call3 floor", 32'(current_floor), 32'd3);

        tick(8'h01, "home");
        run_quiet("home");
        tick(8'h24, "scan25");
        chk("scan25 pending", 32'(pending), 32'h24);
        run_quiet("scan25");
        chk("scan25 floor", 32'(current_floor), 32'd5);

        tick(8'h04, "to2");
        run_quiet("to2");
        tick(8'h40, "to6");
        for (int n = 0; n < 100 && m_floor != 4; n++) tick(8'h00, "to6");
        tick(8'h02, "rev1");
        run_quiet("rev1");
        chk("rev1 floor", 32'(current_floor), 32'd1);

        tick(8'h10, "to4");
        run_quiet("to4");
        seq = '{8'h10, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        door_cnt = 0;
        for (int n = 0; n < 7; n++) begin
            tick(seq[n], "dwell");
            if (n == 0) begin
                chk("dwell door", 32'(door_open), 32'd1);
                chk("dwell pending", 32'(pending), 32'd0);
            end
            if (door_open) door_cnt++;
        end
        chk("dwell length", 32'(door_cnt), 32'd5);

        tick(8'h01, "leave4");
        tick(8'h00, "leave4");
        tick(8'h00, "leave4");
        chk("leave4 moving_down", 32'(moving_down), 32'd1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midreset");
        chk("midreset idle", 32'(idle), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(8'h00, "after_reset");

        for (int n = 0; n < 400; n++)
            tick(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, "random");
        run_quiet("drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
